// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - MA-control bit positions within the 9-bit control word
//   - branch-condition encodings
//   - stage state enum
//   - default memory timeout and the stage latch layout
package ma_stage_pkg;

   localparam int unsigned MaCtrlW = 9;

   // MA-control bit indices
   localparam int unsigned MaMemEn    = 8;
   localparam int unsigned MaMemWr    = 7;
   localparam int unsigned MaHalt     = 6;
   localparam int unsigned MaBranch   = 5;
   localparam int unsigned MaBrCondHi = 4;
   localparam int unsigned MaBrCondLo = 3;
   localparam int unsigned MaJumpImm  = 2;
   localparam int unsigned MaJumpReg  = 1;
   localparam int unsigned MaLink     = 0;

   // Maximum WAIT cycles without an ack before the access is aborted.
   localparam int unsigned TimeoutDefault = 255;

   typedef enum logic [1:0] {
      BrZero    = 2'b00,
      BrNotZero = 2'b01,
      BrNeg     = 2'b10,
      BrNotNeg  = 2'b11
   } br_cond_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StHalt = 2'b10
   } ma_state_e;

   // Everything captured from the EX bundle.
   typedef struct packed {
      logic [MaCtrlW-1:0] ma_ctrl;
      logic [2:0]         wb_ctrl;
      logic [15:0]        ex_out;
      logic [15:0]        rr_data2;
      logic [15:0]        pc_inc2;
      logic [15:0]        pc_add_imm;
      logic               zero;
      logic [2:0]         dst_reg;
   } ma_latch_t;

   // True when the branch condition holds for the given flags.
   function automatic logic br_cond_met(input br_cond_e cond, input logic zero,
                                        input logic sign);
      logic met;
      unique case (cond)
         BrZero:    met = zero;
         BrNotZero: met = ~zero;
         BrNeg:     met = sign;
         BrNotNeg:  met = ~sign;
         default:   met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/ma_branch_resolve.sv
// Combinational branch/jump resolution for the captured bundle.
// Ports:
//   branch, br_cond, jump_imm, jump_reg : decoded MA-control fields
//   zero                                 : ALU zero flag
//   ex_out                               : ALU result (sign bit, jump-register target)
//   pc_add_imm                           : PC-relative target
//   taken                                : redirect required
//   pc_next                              : redirect target
module ma_branch_resolve
   import ma_stage_pkg::*;
(
   input  logic        branch,
   input  logic [1:0]  br_cond,
   input  logic        jump_imm,
   input  logic        jump_reg,
   input  logic        zero,
   input  logic [15:0] ex_out,
   input  logic [15:0] pc_add_imm,
   output logic        taken,
   output logic [15:0] pc_next
);

   always_comb begin
      taken   = jump_imm | jump_reg |
                (branch & br_cond_met(br_cond_e'(br_cond), zero, ex_out[15]));
      pc_next = jump_reg ? ex_out : pc_add_imm;
   end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: latches the EX bundle, resolves redirects, runs
// loads/stores over a req/ack handshake with timeout, and presents a
// one-cycle-valid writeback bundle.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   in_valid .. dst_reg           : EX bundle
//   stall                         : upstream must hold its bundle
//   pc_redirect, pc_next          : one-cycle fetch redirect and target
//   mem_req/mem_wr/mem_addr/mem_wdata, mem_ack/mem_rdata : data memory port
//   out_valid .. out_dst_reg, err : WB bundle (err = access timed out)
//   halted                        : sticky halt indicator
module ma_stage
   import ma_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [MaCtrlW-1:0] in_MA_control,
   input  logic [2:0]         in_WB_control,
   input  logic [15:0]        EX_out,
   input  logic [15:0]        rr_data2,
   input  logic [15:0]        pc_inc2,
   input  logic [15:0]        pc_add_imm,
   input  logic               zero,
   input  logic [2:0]         dst_reg,
   output logic               stall,
   output logic               pc_redirect,
   output logic [15:0]        pc_next,
   output logic               mem_req,
   output logic               mem_wr,
   output logic [15:0]        mem_addr,
   output logic [15:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [15:0]        mem_rdata,
   output logic               out_valid,
   output logic [2:0]         out_WB_control,
   output logic [15:0]        wb_data,
   output logic [2:0]         out_dst_reg,
   output logic               err,
   output logic               halted
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   ma_state_e   state_q, state_d;
   ma_latch_t   lat_q;
   logic        cap_q;        // first cycle after a capture
   logic        out_valid_q;
   logic        err_q;
   logic [15:0] rdata_q;
   logic [CntW-1:0] cnt_q;

   logic        capture;
   logic        wait_ack;
   logic        wait_timeout;
   logic        wait_done;
   logic        br_taken;
   logic [15:0] br_pc_next;

   assign capture      = in_valid & (state_q == StIdle);
   assign wait_ack     = (state_q == StWait) & mem_ack;
   // An ack in the final WAIT cycle still wins over the timeout.
   assign wait_timeout = (state_q == StWait) & ~mem_ack & (cnt_q == CntW'(TIMEOUT - 1));
   assign wait_done    = wait_ack | wait_timeout;

   ma_branch_resolve u_branch_resolve (
      .branch     (lat_q.ma_ctrl[MaBranch]),
      .br_cond    (lat_q.ma_ctrl[MaBrCondHi:MaBrCondLo]),
      .jump_imm   (lat_q.ma_ctrl[MaJumpImm]),
      .jump_reg   (lat_q.ma_ctrl[MaJumpReg]),
      .zero       (lat_q.zero),
      .ex_out     (lat_q.ex_out),
      .pc_add_imm (lat_q.pc_add_imm),
      .taken      (br_taken),
      .pc_next    (br_pc_next)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               if (in_MA_control[MaMemEn]) begin
                  state_d = StWait;
               end else if (in_MA_control[MaHalt]) begin
                  state_d = StHalt;
               end
            end
         end
         StWait: begin
            if (wait_done) begin
               state_d = lat_q.ma_ctrl[MaHalt] ? StHalt : StIdle;
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   // Stage latch, wait counter and WB pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_q       <= '0;
         cap_q       <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         cnt_q       <= '0;
      end else begin
         cap_q       <= capture;
         out_valid_q <= (capture & ~in_MA_control[MaMemEn]) | wait_done;
         err_q       <= wait_timeout;
         if (capture) begin
            lat_q <= '{ma_ctrl:    in_MA_control,
                       wb_ctrl:    in_WB_control,
                       ex_out:     EX_out,
                       rr_data2:   rr_data2,
                       pc_inc2:    pc_inc2,
                       pc_add_imm: pc_add_imm,
                       zero:       zero,
                       dst_reg:    dst_reg};
            cnt_q <= '0;
         end else if (state_q == StWait) begin
            cnt_q <= cnt_q + CntW'(1);
         end
         if (wait_ack) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Outputs
   always_comb begin
      stall          = (state_q != StIdle);
      halted         = (state_q == StHalt);
      // Memory port driven straight from state so reset drops it immediately.
      mem_req        = (state_q == StWait);
      mem_wr         = mem_req & lat_q.ma_ctrl[MaMemWr];
      mem_addr       = mem_req ? lat_q.ex_out : '0;
      mem_wdata      = mem_req ? lat_q.rr_data2 : '0;
      pc_redirect    = cap_q & br_taken;
      pc_next        = br_pc_next;
      out_valid      = out_valid_q;
      err            = err_q;
      out_WB_control = lat_q.wb_ctrl;
      out_dst_reg    = lat_q.dst_reg;
      if (lat_q.ma_ctrl[MaLink]) begin
         wb_data = lat_q.pc_inc2;
      end else if (lat_q.ma_ctrl[MaMemEn] & ~lat_q.ma_ctrl[MaMemWr] & ~err_q) begin
         wb_data = rdata_q;
      end else begin
         wb_data = lat_q.ex_out;
      end
   end

endmodule

// File: tb/tb_ma_stage.sv
module tb_ma_stage;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic        mem_en;
      logic        mem_wr;
      logic        halt;
      logic        branch;
      logic [1:0]  br_cond;
      logic        jump_imm;
      logic        jump_reg;
      logic        link;
      logic [2:0]  wb_ctrl;
      logic [15:0] ex_out;
      logic [15:0] rr_data2;
      logic [15:0] pc_inc2;
      logic [15:0] pc_add_imm;
      logic        zero;
      logic [2:0]  dst_reg;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [8:0]  in_MA_control;
   logic [2:0]  in_WB_control;
   logic [15:0] EX_out, rr_data2, pc_inc2, pc_add_imm;
   logic        zero;
   logic [2:0]  dst_reg;
   logic        stall, pc_redirect;
   logic [15:0] pc_next;
   logic        mem_req, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic [2:0]  out_WB_control;
   logic [15:0] wb_data;
   logic [2:0]  out_dst_reg;
   logic        err, halted;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ma_stage #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_MA_control  (in_MA_control),
      .in_WB_control  (in_WB_control),
      .EX_out         (EX_out),
      .rr_data2       (rr_data2),
      .pc_inc2        (pc_inc2),
      .pc_add_imm     (pc_add_imm),
      .zero           (zero),
      .dst_reg        (dst_reg),
      .stall          (stall),
      .pc_redirect    (pc_redirect),
      .pc_next        (pc_next),
      .mem_req        (mem_req),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .out_valid      (out_valid),
      .out_WB_control (out_WB_control),
      .wb_data        (wb_data),
      .out_dst_reg    (out_dst_reg),
      .err            (err),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: redirect decision straight from the branch rules.
   function automatic logic ref_taken(input bundle_t b);
      logic c;
      case (b.br_cond)
         2'd0:    c = b.zero;
         2'd1:    c = !b.zero;
         2'd2:    c = b.ex_out[15];
         default: c = !b.ex_out[15];
      endcase
      return b.jump_imm || b.jump_reg || (b.branch && c);
   endfunction

   function automatic bundle_t blank();
      bundle_t b;
      b = '0;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.mem_en     = ($urandom_range(0, 2) == 0);
      b.mem_wr     = 1'($urandom_range(0, 1));
      b.halt       = 1'b0;
      b.branch     = 1'($urandom_range(0, 1));
      b.br_cond    = 2'($urandom_range(0, 3));
      b.jump_imm   = ($urandom_range(0, 5) == 0);
      b.jump_reg   = ($urandom_range(0, 5) == 0);
      b.link       = ($urandom_range(0, 3) == 0);
      if (b.mem_en && !b.mem_wr) b.link = 1'b0;
      b.wb_ctrl    = 3'($urandom);
      b.ex_out     = 16'($urandom);
      b.rr_data2   = 16'($urandom);
      b.pc_inc2    = 16'($urandom);
      b.pc_add_imm = 16'($urandom);
      b.zero       = 1'($urandom_range(0, 1));
      b.dst_reg    = 3'($urandom);
      return b;
   endfunction

   task automatic drive(input bundle_t b);
      in_valid      = 1'b1;
      in_MA_control = {b.mem_en, b.mem_wr, b.halt, b.branch, b.br_cond,
                       b.jump_imm, b.jump_reg, b.link};
      in_WB_control = b.wb_ctrl;
      EX_out        = b.ex_out;
      rr_data2      = b.rr_data2;
      pc_inc2       = b.pc_inc2;
      pc_add_imm    = b.pc_add_imm;
      zero          = b.zero;
      dst_reg       = b.dst_reg;
   endtask

   // Issue one bundle at a negedge and follow it to its WB cycle.
   // n_ack: ack arrives in WAIT cycle n_ack (0-based); >= TO means never.
   task automatic send(input bundle_t b, input int n_ack, input logic [15:0] rd);
      logic        taken;
      logic [15:0] tgt, exp_wb;
      bit          is_load, timeout;
      int          req_cycles;
      taken   = ref_taken(b);
      tgt     = b.jump_reg ? b.ex_out : b.pc_add_imm;
      is_load = b.mem_en && !b.mem_wr;
      timeout = b.mem_en && (n_ack >= int'(TO));
      chk("ready_before_issue", stall, 1'b0);
      drive(b);
      mem_ack   = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
      mem_rdata = 16'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      chk("redirect", pc_redirect, taken);
      if (taken) chk("pc_next", pc_next, tgt);
      if (b.mem_en) begin
         req_cycles = timeout ? int'(TO) : n_ack + 1;
         for (int i = 0; i < req_cycles; i++) begin
            if (i > 0) chk("redirect_single", pc_redirect, 1'b0);
            chk("mem_req", mem_req, 1'b1);
            chk("wait_stall", stall, 1'b1);
            chk("mem_wr", mem_wr, b.mem_wr);
            chk("mem_addr", mem_addr, b.ex_out);
            if (b.mem_wr) chk("mem_wdata", mem_wdata, b.rr_data2);
            chk("wait_no_valid", out_valid, 1'b0);
            mem_ack   = !timeout && (i == n_ack);
            mem_rdata = mem_ack ? rd : 16'($urandom);
            @(negedge clk);
            mem_ack = 1'b0;
         end
         chk("req_dropped", mem_req, 1'b0);
      end
      exp_wb = b.link ? b.pc_inc2 : (is_load && !timeout) ? rd : b.ex_out;
      chk("out_valid", out_valid, 1'b1);
      chk("err", err, timeout);
      chk("wb_data", wb_data, exp_wb);
      chk("out_dst_reg", out_dst_reg, b.dst_reg);
      chk("out_wb_ctrl", out_WB_control, b.wb_ctrl);
      chk("stall_after", stall, b.halt);
      chk("halted", halted, b.halt);
   endtask

   initial begin
      bundle_t b;
      rst       = 1'b0;
      in_valid  = 1'b0;
      drive(blank());
      in_valid  = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_redirect", pc_redirect, 1'b0);
      chk("rst_pc_next", pc_next, 16'h0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_wb_data", wb_data, 16'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_halted", halted, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // ALU bundle, then one-cycle valid
      b = blank(); b.ex_out = 16'h1234; b.dst_reg = 3'd3;
      send(b, 0, 16'h0);
      @(negedge clk);
      chk("valid_one_cycle", out_valid, 1'b0);
      chk("alu_no_stall", stall, 1'b0);

      // Load, ack in third WAIT cycle
      b = blank(); b.mem_en = 1'b1; b.ex_out = 16'h0040; b.dst_reg = 3'd5;
      send(b, 2, 16'hBEEF);
      @(negedge clk);

      // Store, immediate ack
      b = blank(); b.mem_en = 1'b1; b.mem_wr = 1'b1; b.ex_out = 16'h0080;
      b.rr_data2 = 16'h00AA;
      send(b, 0, 16'h5555);
      @(negedge clk);
      chk("store_req_gone", mem_req, 1'b0);

      // Branch on zero, taken then not taken
      b = blank(); b.branch = 1'b1; b.br_cond = 2'b00; b.zero = 1'b1;
      b.pc_add_imm = 16'h0100;
      send(b, 0, 16'h0);
      @(negedge clk);
      chk("pulse_one_cycle", pc_redirect, 1'b0);
      b.zero = 1'b0;
      send(b, 0, 16'h0);

      // Load that never gets an ack
      b = blank(); b.mem_en = 1'b1; b.ex_out = 16'h0C0C; b.dst_reg = 3'd1;
      send(b, TO + 3, 16'h0);

      // Back-to-back non-memory bundles
      for (int k = 0; k < 6; k++) begin
         b = rand_bundle(); b.mem_en = 1'b0;
         send(b, 0, 16'h0);
      end

      // Random mix, including redirect-with-memory and timeouts
      for (int k = 0; k < 40; k++) begin
         int n;
         b = rand_bundle();
         n = ($urandom_range(0, 7) == 0) ? int'(TO) + 1 : int'($urandom_range(0, 3));
         send(b, n, 16'($urandom));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);

      // Reset in the middle of WAIT
      b = blank(); b.mem_en = 1'b1; b.ex_out = 16'h0200;
      drive(b);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_req", mem_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_req", mem_req, 1'b0);
      chk("rst_async_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("rst_hold_valid", out_valid, 1'b0);
      chk("rst_hold_err", err, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);

      // Halt bundle, then everything is held off
      b = blank(); b.halt = 1'b1; b.ex_out = 16'h7777; b.dst_reg = 3'd6;
      send(b, 0, 16'h0);
      for (int k = 0; k < 22; k++) begin
         drive(rand_bundle());
         mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("halt_halted", halted, 1'b1);
         chk("halt_stall", stall, 1'b1);
         chk("halt_no_valid", out_valid, 1'b0);
         chk("halt_no_req", mem_req, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the uniprocessor, and the consumer of the execute stage's output bundle (ALU result, store data, PC candidates, zero flag, destination register, MA/WB control). It latches that bundle and resolves branch/jump redirects. It runs data-memory loads and stores over a req/ack handshake against a variable-latency memory, stalling upstream while a transfer is outstanding. It then presents a one-cycle-valid writeback bundle to WB.

## Interface
- TIMEOUT, 255: maximum WAIT cycles without `mem_ack` before the access is aborted with error.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX bundle valid this cycle
- in_MA_control  in  9  [8] mem_en, [7] mem_wr, [6] halt, [5] branch, [4:3] br_cond (00 zero, 01 !zero, 10 EX_out[15], 11 !EX_out[15]), [2] jump_imm, [1] jump_reg, [0] link
- in_WB_control  in  3  passed to WB unchanged
- EX_out  in  16  ALU result / memory address / jump-register target
- rr_data2  in  16  store data
- pc_inc2, pc_add_imm  in  16 each  sequential PC, PC-relative target
- zero  in  1  ALU zero flag
- dst_reg  in  3  destination register
- stall  out  1  upstream must hold its bundle
- pc_redirect  out  1  one-cycle pulse: fetch must load pc_next
- pc_next  out  16  redirect target
- mem_req, mem_wr  out  1 each  memory request, write qualifier
- mem_addr, mem_wdata  out  16 each
- mem_ack  in  1  transfer complete (rdata valid when read)
- mem_rdata  in  16
- out_valid  out  1  WB bundle valid (one cycle)
- out_WB_control  out  3
- wb_data  out  16  link ? pc_inc2 : load ? mem_rdata : EX_out
- out_dst_reg  out  3
- err  out  1  accompanies out_valid: access timed out
- halted  out  1  sticky; set by a halt bundle

## Operation
- Capture: on a clk edge with in_valid=1 and stall=0, all inputs are registered into the stage latch. When stall=1, inputs are ignored.
- State machine IDLE / WAIT / HALT:
  - IDLE, non-memory bundle captured: stays IDLE. out_valid=1 the next cycle.
  - IDLE, bundle with mem_en captured: goes to WAIT. mem_req, mem_wr, mem_addr=EX_out and mem_wdata=rr_data2 are all registered and drive from the next cycle.
  - WAIT: mem_req held and address/data stable. stall=1. A cycle counter increments.
  - WAIT with mem_ack=1: captures mem_rdata, returns to IDLE, and out_valid=1 the next cycle with err=0. stall deasserts in that same next cycle.
  - WAIT, counter reaches TIMEOUT-1 without ack: mem_req drops and state returns to IDLE. out_valid=1 with err=1. wb_data=EX_out.
  - Captured halt bundle: enters HALT after any memory access completes. halted=1 and stall=1 until reset. out_valid is still issued for the halt bundle itself.
- Branch resolve on the captured bundle:
  - Taken when jump_imm, or jump_reg, or (branch and br_cond satisfied).
  - pc_next is EX_out when jump_reg, otherwise pc_add_imm.
  - pc_redirect pulses for exactly one cycle, in the cycle after capture, independent of any memory wait.
- mem_ack outside WAIT is ignored.
- Register writes of the WB bundle occur only when out_valid=1.

## Timing
- Reset values: state IDLE; stage latch valid 0; all outputs 0 (pc_next 0, halted 0, err 0).
- Non-memory latency: capture edge to out_valid = 1 cycle.
- Memory latency: 1 cycle to mem_req, plus N cycles until ack (N≥0: ack in the first WAIT cycle is legal), plus 1 cycle to out_valid.
- Back-to-back non-memory bundles sustain one bundle per cycle.
- Reset asserted mid-WAIT: mem_req drops asynchronously. No out_valid or err is produced for the aborted bundle.
- A redirect and a memory op in the same bundle (link with load is illegal and decoded away upstream): the redirect pulse is issued in the cycle after capture while WAIT is ongoing.

## Structure
- Shared package: MA-control bit indices, br_cond encodings, state enum, and the TIMEOUT default.
- One natural sub-module, ma_branch_resolve: combinational taken/pc_next from control, zero, and EX_out.

## Test plan
- ALU bundle EX_out=16'h1234, dst_reg=3, no mem -> out_valid one cycle later, wb_data=16'h1234, out_dst_reg=3, stall never high.
- Load at EX_out=16'h0040 with mem_ack after 3 WAIT cycles and rdata 16'hBEEF -> mem_req high exactly 3 cycles, stall high throughout, wb_data=16'hBEEF, err=0.
- Store with rr_data2=16'h00AA and immediate ack -> mem_wr=1, mem_wdata=16'h00AA for one cycle, out_valid the next cycle.
- Branch with br_cond=00, zero=1, pc_add_imm=16'h0100 -> pc_redirect one pulse, pc_next=16'h0100. The same bundle with zero=0 -> no pulse.
- Load with no ack at TIMEOUT=4 -> mem_req drops after 4 cycles, then out_valid with err=1.
- rst low during WAIT -> mem_req low immediately and no out_valid. After rst returns high, a halt bundle gives halted=1 and stall=1 held for 20+ cycles.
